corelet_ctrl: RTL and testbench
===============================

// Module: corelet_ctrl
// PURPOSE
//  Top-level sequencer for one corelet. It runs a full conv layer as len_kij passes; each pass is:
//   weight fill -> weight load -> flush -> activation fill -> execute -> drain -> psum writeback.
//  It then runs an accumulate phase that streams psums through the SFP.
//  It sits between the testbench/host start strobe and the corelet, X SRAM and P SRAM.
// PARAMETERS
//  row      8    MAC array rows (L0 depth lanes)
//  col      8    MAC array columns
//  len_kij  9    kernel positions (passes)
//  len_nij  36   activation vectors per pass
//  len_onij 16   output pixels accumulated in ACC phase
//  addr_w   11   SRAM address width
//  w_base   1024 X SRAM base address of weights (kij block = col words)
// PORTS
//  clk         in   1       clock
//  reset       in   1       async active-high reset
//  start       in   1       1-cycle pulse, begin layer; ignored unless IDLE
//  l0_full     in   1       L0 full flag from corelet
//  ofifo_valid in   1       OFIFO has a full row available
//  xmem_rd     out  1       X SRAM read enable (1-cycle read latency)
//  xmem_addr   out  addr_w  X SRAM address
//  l0_wr       out  1       L0 write (corelet registers it, aligning with SRAM data)
//  l0_rd       out  1       L0 read
//  load        out  1       inst_w[0]
//  execute     out  1       inst_w[1]
//  ofifo_rd    out  1       OFIFO pop
//  pmem_wr     out  1       P SRAM write (data = ofifo_out, same cycle as ofifo_rd)
//  pmem_rd     out  1       P SRAM read in ACC phase
//  pmem_addr   out  addr_w  P SRAM address
//  acc         out  1       SFP accumulate (corelet registers it)
//  kij_idx     out  4       current pass index
//  busy        out  1       high in any state except IDLE/DONE
//  done        out  1       1-cycle pulse on entering DONE
// BEHAVIOUR
//  - Reset (async): state=IDLE; all outputs 0; counters 0. Reset mid-operation aborts immediately. No partial state survives.
//  - Outputs are registered (Moore). Each state entry clears the phase counter cnt.
//  - States / transitions:
//   IDLE: start -> W_FILL.
//   W_FILL: col cycles, xmem_rd=l0_wr=1, xmem_addr=w_base+kij*col+cnt -> W_LOAD.
//   W_LOAD: col cycles, l0_rd=load=1 -> W_FLUSH.
//   W_FLUSH: row+col idle cycles -> X_FILL.
//   X_FILL: len_nij cycles, xmem_rd=l0_wr=1, xmem_addr=cnt -> X_EXEC.
//   X_EXEC: len_nij cycles, l0_rd=execute=1 -> X_DRAIN.
//   X_DRAIN: wait until ofifo_valid=1 (no timeout) -> OF_RD.
//   OF_RD: ofifo_rd=pmem_wr=ofifo_valid. pmem_addr=kij*len_nij+rows_done; rows_done increments per pop.
//     At len_nij pops: kij==len_kij-1 -> ACC, else kij++ -> W_FILL.
//   ACC: per output o: len_kij cycles, pmem_rd=1, pmem_addr=k*len_nij+o; acc=1 on cycles k=1..len_kij-1 (k=0 clears).
//     After len_onij outputs -> DONE.
//   DONE: done=1 for one cycle -> IDLE.
//  - OFIFO pops only when ofifo_valid; a gap in valid stalls the OF_RD count, never drops or duplicates a row.
//  - start asserted while busy: ignored. start held high in IDLE: one layer per rising detection (edge-detected).
//  - load and execute are never both 1. l0_wr and l0_rd are never both 1.
//  - kij wraps to 0 on IDLE entry. Counters are sized ceil(log2(max+1)) and never overflow.
// CONFIGURATION
//  CORELET_CTRL_STALL_EN defined:
//   - In W_FILL/X_FILL, l0_full=1 deasserts xmem_rd/l0_wr and holds cnt/xmem_addr until l0_full=0.
//   - busy stays 1 during the stall.
//  CORELET_CTRL_STALL_EN undefined:
//   - l0_full is ignored; fills run fixed-length (L0 must be deep enough).
// TESTING
//  1 reset mid-X_EXEC (kij=3) -> next cycle all outputs 0, busy=0; a fresh start runs from kij=0.
//  2 defaults, start pulse, ofifo_valid tied 1 after X_EXEC:
//    -> exactly 9x(8+36)=396 l0_wr, 9x36=324 ofifo_rd/pmem_wr, 16x9 pmem_rd, then one done pulse.
//  3 W_FILL kij=2 -> xmem_addr 1040..1047 on consecutive cycles; load high 8 cycles, never with execute.
//  4 OF_RD with ofifo_valid toggling 1,0,1,... -> 36 pops total, pmem_addr contiguous, no pmem_wr when valid=0.
//  5 start pulses during busy and during DONE -> no restart; layer completes once.
//  6 STALL_EN: l0_full=1 for 5 cycles at X_FILL cnt=10 -> l0_wr low 5 cycles, xmem_addr holds 10, total writes 36.

Source files
------------

// File: rtl/corelet_ctrl.sv
// corelet_ctrl: top-level sequencer for one corelet.
//
// A conv layer runs as LenKij passes. Each pass does weight fill, weight load, flush,
// activation fill, execute, drain and psum writeback. An accumulate phase then streams
// the psums through the SFP.
//
// Optional feature macro: CORELET_CTRL_STALL_EN
//   defined   - l0_full stalls W_FILL/X_FILL. xmem_rd/l0_wr drop and cnt/xmem_addr hold.
//   undefined - l0_full is ignored and the fills run for a fixed length.
//
// Ports:
//   clk, reset            clock, async active-high reset
//   start                 begin layer (rising edge, IDLE only)
//   l0_full, ofifo_valid  corelet status
//   xmem_rd, xmem_addr    X SRAM read port (1-cycle latency)
//   l0_wr, l0_rd          L0 write/read strobes
//   load, execute         inst_w[0], inst_w[1]
//   ofifo_rd, pmem_wr     OFIFO pop / P SRAM write (same cycle)
//   pmem_rd, pmem_addr    P SRAM read (ACC phase) / P SRAM address
//   acc                   SFP accumulate
//   kij_idx, busy, done   pass index, activity flag, completion pulse
//
// All state and outputs are registered. There are two exceptions. The OFIFO pop is
// qualified by ofifo_valid in the same cycle, so a gap in valid never pops a missing row.
// In stall builds, the fill strobes are qualified by ~l0_full in the same cycle.
module corelet_ctrl #(
  parameter int unsigned Row     = 8,
  parameter int unsigned Col     = 8,
  parameter int unsigned LenKij  = 9,
  parameter int unsigned LenNij  = 36,
  parameter int unsigned LenOnij = 16,
  parameter int unsigned AddrW   = 11,
  parameter int unsigned WBase   = 1024,
  localparam int unsigned KijW   = $clog2(LenKij + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             l0_full,
  input  logic             ofifo_valid,
  output logic             xmem_rd,
  output logic [AddrW-1:0] xmem_addr,
  output logic             l0_wr,
  output logic             l0_rd,
  output logic             load,
  output logic             execute,
  output logic             ofifo_rd,
  output logic             pmem_wr,
  output logic             pmem_rd,
  output logic [AddrW-1:0] pmem_addr,
  output logic             acc,
  output logic [KijW-1:0]  kij_idx,
  output logic             busy,
  output logic             done
);

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  localparam int unsigned CntMax = max2(max2(Row + Col, LenNij), max2(LenKij, Col));
  localparam int unsigned CntW   = $clog2(CntMax + 1);
  localparam int unsigned OW     = $clog2(LenOnij + 1);

  localparam logic [CntW-1:0]  ColLast   = CntW'(Col - 1);
  localparam logic [CntW-1:0]  FlushLast = CntW'(Row + Col - 1);
  localparam logic [CntW-1:0]  NijLast   = CntW'(LenNij - 1);
  localparam logic [CntW-1:0]  KLast     = CntW'(LenKij - 1);
  localparam logic [KijW-1:0]  KijLast   = KijW'(LenKij - 1);
  localparam logic [OW-1:0]    OnijLast  = OW'(LenOnij - 1);
  localparam logic [AddrW-1:0] WBaseA    = AddrW'(WBase);
  localparam logic [AddrW-1:0] ColA      = AddrW'(Col);
  localparam logic [AddrW-1:0] NijA      = AddrW'(LenNij);

  typedef enum logic [3:0] {
    StIdle, StWFill, StWLoad, StWFlush, StXFill, StXExec, StXDrain, StOfRd, StAcc, StDone
  } state_e;

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [KijW-1:0]  kij_q, kij_d;
  logic [OW-1:0]    onij_q, onij_d;
  logic             start_q;

  // Registered outputs, derived from the next state so that they line up with state_q.
  logic             fill_q, fill_d;
  logic [AddrW-1:0] xmem_addr_q, xmem_addr_d;
  logic             l0_rd_q, l0_rd_d;
  logic             load_q, load_d;
  logic             execute_q, execute_d;
  logic             ofrd_q, ofrd_d;
  logic             pmem_rd_q, pmem_rd_d;
  logic [AddrW-1:0] pmem_addr_q, pmem_addr_d;
  logic             acc_q, acc_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic fill_go;
  logic start_rise;

`ifdef CORELET_CTRL_STALL_EN
  assign fill_go = ~l0_full;
`else
  assign fill_go = 1'b1;
  logic unused_l0_full;
  assign unused_l0_full = l0_full;
`endif

  assign start_rise = start & ~start_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    kij_d   = kij_q;
    onij_d  = onij_q;
    unique case (state_q)
      StIdle: begin
        kij_d  = '0;
        onij_d = '0;
        if (start_rise) begin
          state_d = StWFill;
          cnt_d   = '0;
        end
      end
      StWFill: begin
        if (fill_go) begin
          if (cnt_q == ColLast) begin
            state_d = StWLoad;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      StWLoad: begin
        if (cnt_q == ColLast) begin
          state_d = StWFlush;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StWFlush: begin
        if (cnt_q == FlushLast) begin
          state_d = StXFill;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StXFill: begin
        if (fill_go) begin
          if (cnt_q == NijLast) begin
            state_d = StXExec;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      StXExec: begin
        if (cnt_q == NijLast) begin
          state_d = StXDrain;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StXDrain: begin
        if (ofifo_valid) begin
          state_d = StOfRd;
          cnt_d   = '0;
        end
      end
      StOfRd: begin
        // cnt counts rows popped in this pass and only advances on an actual pop.
        if (ofifo_valid) begin
          if (cnt_q == NijLast) begin
            cnt_d = '0;
            if (kij_q == KijLast) begin
              state_d = StAcc;
              onij_d  = '0;
            end else begin
              state_d = StWFill;
              kij_d   = kij_q + 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      StAcc: begin
        // cnt is the kernel position k, onij is the output pixel o.
        if (cnt_q == KLast) begin
          cnt_d = '0;
          if (onij_q == OnijLast) begin
            state_d = StDone;
          end else begin
            onij_d = onij_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
        cnt_d   = '0;
        kij_d   = '0;
        onij_d  = '0;
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
        kij_d   = '0;
        onij_d  = '0;
      end
    endcase
  end

  always_comb begin
    fill_d      = (state_d == StWFill) || (state_d == StXFill);
    xmem_addr_d = '0;
    if (state_d == StWFill) begin
      xmem_addr_d = WBaseA + AddrW'(kij_d) * ColA + AddrW'(cnt_d);
    end else if (state_d == StXFill) begin
      xmem_addr_d = AddrW'(cnt_d);
    end
    l0_rd_d     = (state_d == StWLoad) || (state_d == StXExec);
    load_d      = (state_d == StWLoad);
    execute_d   = (state_d == StXExec);
    ofrd_d      = (state_d == StOfRd);
    pmem_rd_d   = (state_d == StAcc);
    pmem_addr_d = '0;
    if (state_d == StAcc) begin
      pmem_addr_d = AddrW'(cnt_d) * NijA + AddrW'(onij_d);
    end else if (state_d == StOfRd) begin
      pmem_addr_d = AddrW'(kij_d) * NijA + AddrW'(cnt_d);
    end
    // k=0 loads a fresh psum into the SFP, and later positions add to it.
    acc_d  = (state_d == StAcc) && (cnt_d != '0);
    busy_d = (state_d != StIdle) && (state_d != StDone);
    done_d = (state_d == StDone);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      kij_q       <= '0;
      onij_q      <= '0;
      start_q     <= 1'b0;
      fill_q      <= 1'b0;
      xmem_addr_q <= '0;
      l0_rd_q     <= 1'b0;
      load_q      <= 1'b0;
      execute_q   <= 1'b0;
      ofrd_q      <= 1'b0;
      pmem_rd_q   <= 1'b0;
      pmem_addr_q <= '0;
      acc_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      kij_q       <= kij_d;
      onij_q      <= onij_d;
      start_q     <= start;
      fill_q      <= fill_d;
      xmem_addr_q <= xmem_addr_d;
      l0_rd_q     <= l0_rd_d;
      load_q      <= load_d;
      execute_q   <= execute_d;
      ofrd_q      <= ofrd_d;
      pmem_rd_q   <= pmem_rd_d;
      pmem_addr_q <= pmem_addr_d;
      acc_q       <= acc_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign xmem_rd   = fill_q & fill_go;
  assign l0_wr     = fill_q & fill_go;
  assign xmem_addr = xmem_addr_q;
  assign l0_rd     = l0_rd_q;
  assign load      = load_q;
  assign execute   = execute_q;
  assign ofifo_rd  = ofrd_q & ofifo_valid;
  assign pmem_wr   = ofrd_q & ofifo_valid;
  assign pmem_rd   = pmem_rd_q;
  assign pmem_addr = pmem_addr_q;
  assign acc       = acc_q;
  assign kij_idx   = kij_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_corelet_ctrl.sv
`timescale 1ns/1ps
module tb_corelet_ctrl;
  localparam int Row     = 8;
  localparam int Col     = 8;
  localparam int LenKij  = 9;
  localparam int LenNij  = 36;
  localparam int LenOnij = 16;
  localparam int AddrW   = 11;
  localparam int WBase   = 1024;
  localparam int Budget  = 20000;

  logic             clk = 1'b0;
  logic             reset, start, l0_full, ofifo_valid;
  logic             xmem_rd, l0_wr, l0_rd, load, execute, ofifo_rd, pmem_wr, pmem_rd, acc;
  logic             busy, done;
  logic [AddrW-1:0] xmem_addr, pmem_addr;
  logic [3:0]       kij_idx;

  always #5 clk = ~clk;

  corelet_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .l0_full(l0_full), .ofifo_valid(ofifo_valid),
    .xmem_rd(xmem_rd), .xmem_addr(xmem_addr), .l0_wr(l0_wr), .l0_rd(l0_rd), .load(load),
    .execute(execute), .ofifo_rd(ofifo_rd), .pmem_wr(pmem_wr), .pmem_rd(pmem_rd),
    .pmem_addr(pmem_addr), .acc(acc), .kij_idx(kij_idx), .busy(busy), .done(done)
  );

  int n_vec = 0;
  int n_err = 0;

  // Scoreboard queues filled by the reference model when a layer is started.
  int exp_x[$];
  int exp_pw[$];
  int exp_pk[$];
  int exp_pr[$];
  int exp_pa[$];
  int cnt_l0wr, cnt_pop, cnt_prd, cnt_load, cnt_exec, cnt_done;
  int vmode = 0;
  int l0f_pct = 0;

  task automatic check(input string name, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference model: list every transaction a full layer must produce, in order.
  task automatic push_layer();
    for (int k = 0; k < LenKij; k++) begin
      for (int c = 0; c < Col; c++) exp_x.push_back(WBase + k * Col + c);
      for (int n = 0; n < LenNij; n++) exp_x.push_back(n);
      for (int r = 0; r < LenNij; r++) begin
        exp_pw.push_back(k * LenNij + r);
        exp_pk.push_back(k);
      end
    end
    for (int o = 0; o < LenOnij; o++) begin
      for (int k = 0; k < LenKij; k++) begin
        exp_pr.push_back(k * LenNij + o);
        exp_pa.push_back(k != 0);
      end
    end
  endtask

  task automatic clear_sb();
    exp_x.delete();
    exp_pw.delete();
    exp_pk.delete();
    exp_pr.delete();
    exp_pa.delete();
    cnt_l0wr = 0; cnt_pop = 0; cnt_prd = 0; cnt_load = 0; cnt_exec = 0; cnt_done = 0;
  endtask

  // Input driver for the corelet status flags.
  initial begin
    ofifo_valid = 1'b0;
    l0_full     = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (vmode)
        0:       ofifo_valid = 1'b1;
        1:       ofifo_valid = ~ofifo_valid;
        default: ofifo_valid = ($urandom_range(0, 99) < 60);
      endcase
      l0_full = ($urandom_range(0, 99) < l0f_pct);
    end
  end

  // Monitor: sample mid-cycle and pop the scoreboard on every DUT transaction.
  always @(negedge clk) begin
    if (!reset) begin
      check("load_exec_excl", int'(load & execute), 0);
      check("l0_wr_rd_excl", int'(l0_wr & l0_rd), 0);
      check("l0_wr_eq_xmem_rd", int'(l0_wr), int'(xmem_rd));
      check("pmem_wr_eq_ofifo_rd", int'(pmem_wr), int'(ofifo_rd));
      check("pop_needs_valid", int'(ofifo_rd & ~ofifo_valid), 0);
      check("busy_when_active", int'((xmem_rd | l0_rd | ofifo_rd | pmem_rd) & ~busy), 0);
`ifdef CORELET_CTRL_STALL_EN
      check("no_fill_when_full", int'(xmem_rd & l0_full), 0);
`endif
      if (load) cnt_load++;
      if (execute) cnt_exec++;
      if (done) cnt_done++;
      if (xmem_rd) begin
        cnt_l0wr++;
        check("xmem_q_nonempty", int'(exp_x.size() > 0), 1);
        if (exp_x.size() > 0) check("xmem_addr", int'(xmem_addr), exp_x.pop_front());
      end
      if (pmem_wr) begin
        cnt_pop++;
        check("pw_q_nonempty", int'(exp_pw.size() > 0), 1);
        if (exp_pw.size() > 0) begin
          check("pmem_wr_addr", int'(pmem_addr), exp_pw.pop_front());
          check("kij_idx", int'(kij_idx), exp_pk.pop_front());
        end
      end
      if (pmem_rd) begin
        cnt_prd++;
        check("pr_q_nonempty", int'(exp_pr.size() > 0), 1);
        if (exp_pr.size() > 0) begin
          check("pmem_rd_addr", int'(pmem_addr), exp_pr.pop_front());
          check("acc", int'(acc), exp_pa.pop_front());
        end
      end else begin
        check("acc_only_in_rd", int'(acc), 0);
      end
    end
  end

  task automatic check_quiet(input string tag);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_done"}, int'(done), 0);
    check({tag, "_xmem_rd"}, int'(xmem_rd), 0);
    check({tag, "_xmem_addr"}, int'(xmem_addr), 0);
    check({tag, "_l0_rd"}, int'(l0_rd), 0);
    check({tag, "_load"}, int'(load), 0);
    check({tag, "_execute"}, int'(execute), 0);
    check({tag, "_ofifo_rd_gate"}, int'(ofifo_rd), 0);
    check({tag, "_pmem_rd"}, int'(pmem_rd), 0);
    check({tag, "_pmem_addr"}, int'(pmem_addr), 0);
    check({tag, "_acc"}, int'(acc), 0);
    check({tag, "_kij_idx"}, int'(kij_idx), 0);
  endtask

  // style 0: single pulse; 1: start held high throughout; 2: random pulses while busy + in DONE
  task automatic run_layer(input int vm, input int pct, input int style);
    int cyc;
    int got;
    clear_sb();
    push_layer();
    vmode   = vm;
    l0f_pct = pct;
    start   = 1'b1;
    @(posedge clk);
    #1;
    if (style != 1) start = 1'b0;
    cyc = 0;
    got = 0;
    while (got == 0 && cyc < Budget) begin
      if (style == 2) start = ($urandom_range(0, 15) == 0);
      @(posedge clk);
      #1;
      cyc++;
      if (done) got = 1;
    end
    check("done_within_budget", got, 1);
    if (style != 0) start = 1'b1;  // start seen during DONE must not restart
    repeat (3) @(posedge clk);
    #1;
    start = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check("idle_after_layer", int'(busy), 0);
    check("done_pulses", cnt_done, 1);
    check("l0_wr_total", cnt_l0wr, LenKij * (Col + LenNij));
    check("pop_total", cnt_pop, LenKij * LenNij);
    check("pmem_rd_total", cnt_prd, LenOnij * LenKij);
    check("load_total", cnt_load, LenKij * Col);
    check("exec_total", cnt_exec, LenKij * LenNij);
    check("x_left", exp_x.size(), 0);
    check("pw_left", exp_pw.size(), 0);
    check("pr_left", exp_pr.size(), 0);
  endtask

  initial begin
    int cyc;
    int hit;
    reset = 1'b1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_quiet("rst");
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Abort a layer mid-execute on pass 3.
    clear_sb();
    push_layer();
    vmode = 0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    cyc = 0;
    hit = 0;
    while (hit == 0 && cyc < Budget) begin
      @(posedge clk);
      #1;
      cyc++;
      if (execute && kij_idx == 4'd3) hit = 1;
    end
    check("reach_exec_kij3", hit, 1);
    reset = 1'b1;
    #1;
    check_quiet("abort");
    @(posedge clk);
    #1;
    check_quiet("abort_hold");
    reset = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("idle_after_abort", int'(busy), 0);

    run_layer(0, 0, 0);
    run_layer(1, 20, 1);
    run_layer(2, 30, 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
